// File: rtl/echo_request_arbiter_if.sv
// echo_request_arbiter_if: per-source say-style request bundle plus the shared pipe.enq invocation
interface echo_request_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
);
  logic [NUM_REQ-1:0]            req_ena;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_meth;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_v;
  logic [NUM_REQ-1:0]            req_rdy;
  logic                          enq_ena;
  logic [TAG_WIDTH-1:0]          enq_tag;
  logic [DATA_WIDTH-1:0]         enq_meth;
  logic [DATA_WIDTH-1:0]         enq_v;
  logic                          enq_rdy;
  modport master (
    input  req_ena, req_meth, req_v, enq_rdy,
    output req_rdy, enq_ena, enq_tag, enq_meth, enq_v
  );
  modport slave (
    output req_ena, req_meth, req_v, enq_rdy,
    input  req_rdy, enq_ena, enq_tag, enq_meth, enq_v
  );
endinterface

// File: rtl/echo_request_arbiter.sv
// echo_request_arbiter: one-deep slot per source, round-robin/fixed arbitration onto a registered pipe.enq; ECHO_ARB_STATS_EN adds grant/stall counters
module echo_request_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  prio_mode,
  echo_request_arbiter_if.master bus
`ifdef ECHO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_grants,
  output logic [15:0]           stat_stalls
`endif
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    slot_full_q, slot_full_d;
  logic [DATA_WIDTH-1:0] slot_meth_q [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_meth_d [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_v_q [NUM_REQ];
  logic [DATA_WIDTH-1:0] slot_v_d [NUM_REQ];
  logic                  out_valid_q, out_valid_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic [DATA_WIDTH-1:0] out_meth_q, out_meth_d;
  logic [DATA_WIDTH-1:0] out_v_q, out_v_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         win_fix, win_rr, win;
  logic                  any_full, transfer, load;

  assign any_full = |slot_full_q;
  assign transfer = out_valid_q && bus.enq_rdy;
  assign load     = (!out_valid_q || transfer) && any_full;
  assign win      = prio_mode ? win_fix : win_rr;

  assign bus.req_rdy  = ~slot_full_q;
  assign bus.enq_ena  = out_valid_q;
  assign bus.enq_tag  = out_tag_q;
  assign bus.enq_meth = out_meth_q;
  assign bus.enq_v    = out_v_q;

  // candidate winners: lowest full index, and first full index at or after rr_ptr
  always_comb begin
    logic [PW-1:0] idx;
    win_fix = '0;
    win_rr  = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'(k);
      if (slot_full_q[idx]) win_fix = idx;
      idx = PW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (slot_full_q[idx]) win_rr = idx;
    end
  end

  // slots capture on accept and empty when moved into the output register
  always_comb begin
    slot_full_d = slot_full_q;
    slot_meth_d = slot_meth_q;
    slot_v_d    = slot_v_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_ena[i] && !slot_full_q[i]) begin
        slot_full_d[i] = 1'b1;
        slot_meth_d[i] = bus.req_meth[i*DATA_WIDTH +: DATA_WIDTH];
        slot_v_d[i]    = bus.req_v[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (load) slot_full_d[win] = 1'b0;
  end

  // output register loads the winner, holds under backpressure, and advances rr_ptr in round-robin mode
  always_comb begin
    out_valid_d = load || (out_valid_q && !transfer);
    out_tag_d   = load ? TAG_WIDTH'(win) + TAG_WIDTH'(1) : out_tag_q;
    out_meth_d  = load ? slot_meth_q[win] : out_meth_q;
    out_v_d     = load ? slot_v_q[win] : out_v_q;
    rr_ptr_d    = (load && !prio_mode) ? ((int'(win) == NUM_REQ - 1) ? '0 : win + PW'(1)) : rr_ptr_q;
  end

  // state registers with synchronous active-low reset discarding all buffered work
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      slot_full_q <= '0;
      slot_meth_q <= '{default: '0};
      slot_v_q    <= '{default: '0};
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_meth_q  <= '0;
      out_v_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_meth_q <= slot_meth_d;
      slot_v_q    <= slot_v_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_meth_q  <= out_meth_d;
      out_v_q     <= out_v_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef ECHO_ARB_STATS_EN
  logic [15:0] grant_q [NUM_REQ];
  logic [15:0] grant_d [NUM_REQ];
  logic [15:0] stall_q, stall_d;

  // saturating per-source grant counts and output stall-cycle count
  always_comb begin
    grant_d = grant_q;
    for (int i = 0; i < NUM_REQ; i++)
      if (load && int'(win) == i && grant_q[i] != 16'hFFFF) grant_d[i] = grant_q[i] + 16'd1;
    stall_d = (out_valid_q && !bus.enq_rdy && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end

  // counters cleared only by reset
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      grant_q <= '{default: '0};
      stall_q <= '0;
    end else begin
      grant_q <= grant_d;
      stall_q <= stall_d;
    end
  end

  // flatten grant counters, slice i = source i
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[i*16 +: 16] = grant_q[i];
  end

  assign stat_stalls = stall_q;
`endif
endmodule

// File: tb/tb_echo_request_arbiter.sv
// tb_echo_request_arbiter: scoreboard bench for reset, latency, arbitration, backpressure and mid-run reset
module tb_echo_request_arbiter;
  localparam int NR = 2;
  localparam int DW = 32;
  localparam int TW = 8;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic prio_mode = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int seq = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [TW-1:0] tagq[$];

  echo_request_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus();

`ifdef ECHO_ARB_STATS_EN
  logic [NR*16-1:0] stat_grants;
  logic [15:0] stat_stalls;
`endif

  echo_request_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .prio_mode(prio_mode),
    .bus(bus)
`ifdef ECHO_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stalls(stat_stalls)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    nRST = 1'b0;
    bus.req_ena = '0;
    bus.enq_rdy = 1'b1;
    prio_mode = 1'b0;
    step();
    step();
    nRST = 1'b1;
    q0.delete();
    q1.delete();
    tagq.delete();
  endtask

  task automatic drive_one(input int s, input logic [31:0] m, input logic [31:0] v);
    if (bus.req_rdy[s]) begin
      bus.req_ena[s] = 1'b1;
      bus.req_meth[s*DW +: DW] = m;
      bus.req_v[s*DW +: DW] = v;
      if (s == 0) q0.push_back({m, v});
      else q1.push_back({m, v});
    end
  endtask

  task automatic drive(input logic [1:0] mask);
    bus.req_ena = '0;
    for (int s = 0; s < NR; s++) begin
      if (mask[s]) begin
        drive_one(s, {8'(s), 24'(seq)}, $urandom);
        seq++;
      end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.req_ena = 2'b11;
    bus.req_meth = '1;
    bus.req_v = '1;
    bus.enq_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if ({bus.enq_ena, bus.enq_tag, bus.enq_meth, bus.enq_v} !== '0) begin
        n_bad++;
        $display("FAIL reset_out c=%0d: got ena=%0b tag=%0h meth=%0h v=%0h, required all zero", c, bus.enq_ena, bus.enq_tag, bus.enq_meth, bus.enq_v);
      end
    end
    nRST = 1'b1;
    bus.req_ena = '0;
    step();
    n_cmp++;
    if (bus.req_rdy !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_rdy: got %b, required 11", bus.req_rdy);
    end
    step();
    n_cmp++;
    if (bus.enq_ena !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_capture: enq_ena got %b, required 0", bus.enq_ena);
    end
  endtask

  task automatic test_single();
    logic [TW-1:0] et;
    logic [63:0] ed;
    int first = -1;
    int last = -1;
    int sent = 0;
    apply_reset();
    bus.req_ena = '0;
    drive_one(0, 32'd1, 32'hA5);
    tagq.push_back(8'd1);
    step();
    bus.req_ena = '0;
    n_cmp++;
    if (bus.req_rdy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_rdy_t1: got %b, required 0", bus.req_rdy[0]);
    end
    n_cmp++;
    if (bus.enq_ena !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ena_t1: got %b, required 0", bus.enq_ena);
    end
    step();
    n_cmp++;
    if (bus.enq_ena !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ena_t2: got %b, required 1", bus.enq_ena);
    end
    n_cmp++;
    if (bus.req_rdy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL single_rdy_t2: got %b, required 1", bus.req_rdy[0]);
    end
    for (int c = 0; c < 20; c++) begin
      if (bus.enq_ena && bus.enq_rdy) begin
        if (first < 0) first = c;
        last = c;
        n_cmp++;
        if (tagq.size() == 0) begin
          n_bad++;
          $display("FAIL single_extra: tag %0d observed, none required", bus.enq_tag);
        end else begin
          et = tagq.pop_front();
          ed = '0;
          if (q0.size() > 0) ed = q0.pop_front();
          if (bus.enq_tag !== et) begin
            n_bad++;
            $display("FAIL single_tag: got %0d, required %0d", bus.enq_tag, et);
          end
          n_cmp++;
          if ({bus.enq_meth, bus.enq_v} !== ed) begin
            n_bad++;
            $display("FAIL single_data: got %h, required %h", {bus.enq_meth, bus.enq_v}, ed);
          end
        end
      end
      bus.req_ena = '0;
      if (sent < 3 && bus.req_rdy[0]) begin
        drive_one(0, 32'(100 + sent), $urandom);
        tagq.push_back(8'd1);
        sent++;
      end
      step();
    end
    n_cmp++;
    if (last - first != 6) begin
      n_bad++;
      $display("FAIL single_rate: 4 msgs spanned %0d cycles, required 6", last - first);
    end
    n_cmp++;
    if (tagq.size() != 0 || q0.size() != 0) begin
      n_bad++;
      $display("FAIL single_drain: %0d msgs left, required 0", tagq.size());
    end
  endtask

  task automatic test_arbitration(input logic fixed);
    logic [TW-1:0] et;
    logic [63:0] ed;
    int first = -1;
    int last = -1;
    int cnt0 = 0;
    int cnt1 = 0;
    apply_reset();
    bus.req_ena = '0;
    drive_one(0, 32'h1, 32'h1);
    tagq.push_back(8'd1);
    for (int c = 0; c < 4; c++) begin
      step();
      bus.req_ena = '0;
      if (bus.enq_ena && bus.enq_rdy) begin
        n_cmp++;
        et = tagq.size() > 0 ? tagq.pop_front() : '0;
        ed = q0.size() > 0 ? q0.pop_front() : '0;
        if ({bus.enq_tag, bus.enq_meth, bus.enq_v} !== {et, ed}) begin
          n_bad++;
          $display("FAIL arb_pre mode=%0d: got tag=%0d data=%h, required tag=%0d data=%h", fixed, bus.enq_tag, {bus.enq_meth, bus.enq_v}, et, ed);
        end
      end
    end
    prio_mode = fixed;
    for (int k = 0; k < 8; k++) tagq.push_back(((k % 2 == 0) == fixed) ? 8'd1 : 8'd2);
    for (int c = 0; c < 20; c++) begin
      drive({cnt1 < 4, cnt0 < 4});
      cnt0 += int'(bus.req_ena[0]);
      cnt1 += int'(bus.req_ena[1]);
      step();
      bus.req_ena = '0;
      if (bus.enq_ena && bus.enq_rdy) begin
        if (first < 0) first = c;
        last = c;
        n_cmp++;
        if (tagq.size() == 0) begin
          n_bad++;
          $display("FAIL arb_extra mode=%0d: tag %0d observed, none required", fixed, bus.enq_tag);
        end else begin
          et = tagq.pop_front();
          ed = '0;
          if (et == 8'd1 && q0.size() > 0) ed = q0.pop_front();
          if (et == 8'd2 && q1.size() > 0) ed = q1.pop_front();
          if (bus.enq_tag !== et) begin
            n_bad++;
            $display("FAIL arb_tag mode=%0d c=%0d: got %0d, required %0d", fixed, c, bus.enq_tag, et);
          end
          n_cmp++;
          if ({bus.enq_meth, bus.enq_v} !== ed) begin
            n_bad++;
            $display("FAIL arb_data mode=%0d c=%0d: got %h, required %h", fixed, c, {bus.enq_meth, bus.enq_v}, ed);
          end
        end
      end
    end
    n_cmp++;
    if (last - first != 7) begin
      n_bad++;
      $display("FAIL arb_rate mode=%0d: 8 msgs spanned %0d cycles, required 7", fixed, last - first);
    end
    n_cmp++;
    if (tagq.size() != 0 || q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL arb_drain mode=%0d: %0d tags left, required 0", fixed, tagq.size());
    end
    prio_mode = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] et;
    logic [63:0] ed;
    int first = -1;
    int last = -1;
    apply_reset();
    bus.enq_rdy = 1'b0;
    bus.req_ena = '0;
    drive_one(1, 32'd7, 32'h55);
    tagq.push_back(8'd2);
    step();
    bus.req_ena = '0;
    step();
    drive_one(0, 32'd8, 32'h11);
    drive_one(1, 32'd9, 32'h66);
    tagq.push_back(8'd1);
    tagq.push_back(8'd2);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({bus.enq_ena, bus.enq_tag, bus.enq_meth, bus.enq_v} !== {1'b1, 8'd2, 32'd7, 32'h55}) begin
        n_bad++;
        $display("FAIL bp_hold c=%0d: got ena=%b tag=%0d meth=%0h v=%0h, required 1/2/7/55", c, bus.enq_ena, bus.enq_tag, bus.enq_meth, bus.enq_v);
      end
      if (c >= 1) begin
        n_cmp++;
        if (bus.req_rdy !== 2'b00) begin
          n_bad++;
          $display("FAIL bp_rdy c=%0d: got %b, required 00", c, bus.req_rdy);
        end
      end
      step();
      bus.req_ena = '0;
    end
    bus.enq_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.enq_ena && bus.enq_rdy) begin
        if (first < 0) first = c;
        last = c;
        n_cmp++;
        if (tagq.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra: tag %0d observed, none required", bus.enq_tag);
        end else begin
          et = tagq.pop_front();
          ed = '0;
          if (et == 8'd1 && q0.size() > 0) ed = q0.pop_front();
          if (et == 8'd2 && q1.size() > 0) ed = q1.pop_front();
          if (bus.enq_tag !== et) begin
            n_bad++;
            $display("FAIL bp_tag c=%0d: got %0d, required %0d", c, bus.enq_tag, et);
          end
          n_cmp++;
          if ({bus.enq_meth, bus.enq_v} !== ed) begin
            n_bad++;
            $display("FAIL bp_data c=%0d: got %h, required %h", c, {bus.enq_meth, bus.enq_v}, ed);
          end
        end
      end
      step();
    end
    n_cmp++;
    if (last - first != 2) begin
      n_bad++;
      $display("FAIL bp_rate: 3 msgs spanned %0d cycles, required 2", last - first);
    end
    n_cmp++;
    if (tagq.size() != 0 || q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL bp_drain: %0d tags left, required 0", tagq.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [TW-1:0] et;
    logic [63:0] ed;
    apply_reset();
    bus.enq_rdy = 1'b0;
    bus.req_ena = '0;
    drive_one(0, 32'd1, 32'h1);
    drive_one(1, 32'd2, 32'h2);
    step();
    bus.req_ena = '0;
    step();
    drive_one(0, 32'd3, 32'h3);
    step();
    bus.req_ena = '0;
    n_cmp++;
    if ({bus.enq_ena, bus.req_rdy} !== 3'b100) begin
      n_bad++;
      $display("FAIL mid_pre: got ena=%b rdy=%b, required 1/00", bus.enq_ena, bus.req_rdy);
    end
    nRST = 1'b0;
    step();
    n_cmp++;
    if ({bus.enq_ena, bus.enq_tag, bus.enq_meth, bus.enq_v} !== '0) begin
      n_bad++;
      $display("FAIL mid_out: got ena=%b tag=%0d meth=%0h v=%0h, required all zero", bus.enq_ena, bus.enq_tag, bus.enq_meth, bus.enq_v);
    end
    nRST = 1'b1;
    q0.delete();
    q1.delete();
    tagq.delete();
    step();
    n_cmp++;
    if ({bus.enq_ena, bus.req_rdy} !== 3'b011) begin
      n_bad++;
      $display("FAIL mid_post: got ena=%b rdy=%b, required 0/11", bus.enq_ena, bus.req_rdy);
    end
    bus.enq_rdy = 1'b1;
    drive_one(0, 32'd4, 32'h4);
    drive_one(1, 32'd5, 32'h5);
    tagq.push_back(8'd1);
    tagq.push_back(8'd2);
    for (int c = 0; c < 6; c++) begin
      step();
      bus.req_ena = '0;
      if (bus.enq_ena && bus.enq_rdy) begin
        n_cmp++;
        if (tagq.size() == 0) begin
          n_bad++;
          $display("FAIL mid_extra: tag %0d observed, none required", bus.enq_tag);
        end else begin
          et = tagq.pop_front();
          ed = '0;
          if (et == 8'd1 && q0.size() > 0) ed = q0.pop_front();
          if (et == 8'd2 && q1.size() > 0) ed = q1.pop_front();
          if ({bus.enq_tag, bus.enq_meth, bus.enq_v} !== {et, ed}) begin
            n_bad++;
            $display("FAIL mid_tie: got tag=%0d data=%h, required tag=%0d data=%h", bus.enq_tag, {bus.enq_meth, bus.enq_v}, et, ed);
          end
        end
      end
    end
    n_cmp++;
    if (tagq.size() != 0) begin
      n_bad++;
      $display("FAIL mid_drain: %0d tags left, required 0", tagq.size());
    end
  endtask

`ifdef ECHO_ARB_STATS_EN
  task automatic test_stats();
    int cnt0 = 0;
    int cnt1 = 0;
    apply_reset();
    n_cmp++;
    if ({stat_grants, stat_stalls} !== '0) begin
      n_bad++;
      $display("FAIL stats_reset: got grants=%h stalls=%0d, required 0", stat_grants, stat_stalls);
    end
    for (int c = 0; c < 20; c++) begin
      bus.enq_rdy = !(c >= 3 && c < 7);
      drive({cnt1 < 2, cnt0 < 3});
      cnt0 += int'(bus.req_ena[0]);
      cnt1 += int'(bus.req_ena[1]);
      step();
      bus.req_ena = '0;
    end
    n_cmp++;
    if (stat_grants !== {16'd2, 16'd3}) begin
      n_bad++;
      $display("FAIL stats_grants: got %h, required 00020003", stat_grants);
    end
    n_cmp++;
    if (stat_stalls !== 16'd4) begin
      n_bad++;
      $display("FAIL stats_stalls: got %0d, required 4", stat_stalls);
    end
    q0.delete();
    q1.delete();
  endtask
`endif

  initial begin
    bus.req_ena = '0;
    bus.req_meth = '0;
    bus.req_v = '0;
    bus.enq_rdy = 1'b1;
    test_reset();
    test_single();
    test_arbitration(1'b0);
    test_arbitration(1'b1);
    test_backpressure();
    test_reset_mid();
`ifdef ECHO_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
